// File: rtl/control_unit_v3_if.sv
// control_unit_v3_if: bundles the instruction/PC inputs, the register-file
// handshake flags and every control output of control_unit_v3.
// master = the control unit, slave = the datapath / register file side.
interface control_unit_v3_if #(
    parameter int DATA_W = 8
);
    logic [3*DATA_W-1:0] command_word;
    logic [DATA_W-1:0]   pc_value;
    logic [1:0]          ReadyRegFlag;

    logic [DATA_W-1:0]   PC_load;
    logic                PC_inc;
    logic                PC_en;
    logic                MAR_load;
    logic                IR_load;
    logic [DATA_W-1:0]   write_data;
    logic [DATA_W-1:0]   ALU_sel;
    logic [DATA_W-1:0]   ADR_1;
    logic [DATA_W-1:0]   ADR_2;
    logic [DATA_W-1:0]   ADR_3;
    logic                regReadEnable;
    logic                regWriteEnable;
    logic                stack_overflow;
    logic                stack_underflow;
    logic                illegal_op;

    modport master (
        input  command_word, pc_value, ReadyRegFlag,
        output PC_load, PC_inc, PC_en, MAR_load, IR_load, write_data, ALU_sel,
               ADR_1, ADR_2, ADR_3, regReadEnable, regWriteEnable,
               stack_overflow, stack_underflow, illegal_op
    );

    modport slave (
        output command_word, pc_value, ReadyRegFlag,
        input  PC_load, PC_inc, PC_en, MAR_load, IR_load, write_data, ALU_sel,
               ADR_1, ADR_2, ADR_3, regReadEnable, regWriteEnable,
               stack_overflow, stack_underflow, illegal_op
    );
endinterface

// File: rtl/control_unit_v3.sv
// control_unit_v3: multi-cycle instruction sequencer (fetch / load IR /
// decode / register read / execute / writeback) with a register-file
// handshake and an optional return-address stack for CALL/RET.
// Optional feature macro: CU_CALL_STACK_EN. When undefined, no stack is
// built, CALL (0x1A) and RET (0x1B) decode as illegal, and both stack
// error flags are held at 0.
//
// state     | meaning
// FETCH     | strobe MAR with the PC
// LOAD_IR   | capture command_word, advance PC
// DECODE    | dispatch on the latched opcode, flag undefined opcodes
// READ      | register-file read request, wait for read-valid
// EXECUTE   | one-cycle PC redirect (JMP/CALL/RET)
// WRITEBACK | register-file write request, wait for write-accept
//
// Outputs are decoded combinationally from current_state and the latched
// instruction, and forced low while rst is high so reset clears them at once.
module control_unit_v3 #(
    parameter int DATA_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    control_unit_v3_if.master  bus
);
    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        LOAD_IR   = 3'd1,
        DECODE    = 3'd2,
        READ      = 3'd3,
        EXECUTE   = 3'd4,
        WRITEBACK = 3'd5
    } state_t;

    localparam logic [DATA_W-1:0] OP_NOP  = DATA_W'(8'h00);
    localparam logic [DATA_W-1:0] OP_STR  = DATA_W'(8'h01);
    localparam logic [DATA_W-1:0] OP_ADD  = DATA_W'(8'h03);
    localparam logic [DATA_W-1:0] OP_SUB  = DATA_W'(8'h04);
    localparam logic [DATA_W-1:0] OP_JMP  = DATA_W'(8'h19);
    localparam logic [DATA_W-1:0] OP_MOV  = DATA_W'(8'h1C);

    localparam logic [DATA_W-1:0] ALU_PASS = DATA_W'(8'h00);
    localparam logic [DATA_W-1:0] ALU_ADD  = DATA_W'(8'h01);
    localparam logic [DATA_W-1:0] ALU_SUB  = DATA_W'(8'h02);

    state_t              current_state;
    logic [DATA_W-1:0]   r_opcode;
    logic [DATA_W-1:0]   r_op1;
    logic [DATA_W-1:0]   r_op2;
    logic                w_legal;

`ifdef CU_CALL_STACK_EN
    localparam logic [DATA_W-1:0] OP_CALL = DATA_W'(8'h1A);
    localparam logic [DATA_W-1:0] OP_RET  = DATA_W'(8'h1B);
    localparam int AW  = $clog2(STACK_DEPTH);
    localparam int SPW = AW + 1;

    logic [DATA_W-1:0]   r_stack [STACK_DEPTH];
    logic [SPW-1:0]      r_sp;
    logic                r_ovf;
    logic                r_unf;
    logic                w_full;
    logic                w_empty;
    logic [AW-1:0]       w_push_idx;
    logic [AW-1:0]       w_top_idx;

    assign w_full     = (r_sp == SPW'(STACK_DEPTH));
    assign w_empty    = (r_sp == '0);
    assign w_push_idx = AW'(r_sp);
    assign w_top_idx  = AW'(r_sp - SPW'(1));

    assign w_legal = (r_opcode == OP_NOP) || (r_opcode == OP_STR) ||
                     (r_opcode == OP_ADD) || (r_opcode == OP_SUB) ||
                     (r_opcode == OP_MOV) || (r_opcode == OP_JMP) ||
                     (r_opcode == OP_CALL) || (r_opcode == OP_RET);

    assign bus.stack_overflow  = r_ovf;
    assign bus.stack_underflow = r_unf;

    // Return stack: push pc_value on CALL, pop on RET; full/empty set sticky flags instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (current_state == EXECUTE) begin
            if (r_opcode == OP_CALL) begin
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_stack[w_push_idx] <= bus.pc_value;
                    r_sp                <= r_sp + SPW'(1);
                end
            end else if (r_opcode == OP_RET) begin
                if (w_empty) begin
                    r_unf <= 1'b1;
                end else begin
                    r_sp <= r_sp - SPW'(1);
                end
            end
        end
    end
`else
    logic w_unused_pc;

    assign w_unused_pc = ^bus.pc_value;

    assign w_legal = (r_opcode == OP_NOP) || (r_opcode == OP_STR) ||
                     (r_opcode == OP_ADD) || (r_opcode == OP_SUB) ||
                     (r_opcode == OP_MOV) || (r_opcode == OP_JMP);

    assign bus.stack_overflow  = 1'b0;
    assign bus.stack_underflow = 1'b0;
`endif

    // Sequencer state and instruction latch (command_word is only sampled in LOAD_IR).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            current_state <= FETCH;
            r_opcode      <= '0;
            r_op1         <= '0;
            r_op2         <= '0;
        end else begin
            case (current_state)
                FETCH: current_state <= LOAD_IR;
                LOAD_IR: begin
                    r_opcode      <= bus.command_word[3*DATA_W-1 -: DATA_W];
                    r_op1         <= bus.command_word[2*DATA_W-1 -: DATA_W];
                    r_op2         <= bus.command_word[DATA_W-1:0];
                    current_state <= DECODE;
                end
                DECODE: begin
                    case (r_opcode)
                        OP_STR:                 current_state <= WRITEBACK;
                        OP_ADD, OP_SUB, OP_MOV: current_state <= READ;
                        OP_JMP:                 current_state <= EXECUTE;
`ifdef CU_CALL_STACK_EN
                        OP_CALL, OP_RET:        current_state <= EXECUTE;
`endif
                        default:                current_state <= FETCH;
                    endcase
                end
                READ: begin
                    if (bus.ReadyRegFlag[0]) current_state <= WRITEBACK;
                end
                WRITEBACK: begin
                    if (bus.ReadyRegFlag[1]) current_state <= FETCH;
                end
                EXECUTE: current_state <= FETCH;
                default: current_state <= FETCH;
            endcase
        end
    end

    // Control outputs decoded from state and latched instruction; all low during reset.
    always_comb begin
        bus.PC_load        = '0;
        bus.PC_inc         = 1'b0;
        bus.PC_en          = 1'b0;
        bus.MAR_load       = 1'b0;
        bus.IR_load        = 1'b0;
        bus.write_data     = '0;
        bus.ALU_sel        = ALU_PASS;
        bus.ADR_1          = '0;
        bus.ADR_2          = '0;
        bus.ADR_3          = '0;
        bus.regReadEnable  = 1'b0;
        bus.regWriteEnable = 1'b0;
        bus.illegal_op     = 1'b0;
        if (!rst) begin
            case (current_state)
                FETCH: bus.MAR_load = 1'b1;
                LOAD_IR: begin
                    bus.IR_load = 1'b1;
                    bus.PC_inc  = 1'b1;
                    bus.PC_en   = 1'b1;
                end
                DECODE: bus.illegal_op = !w_legal;
                READ: begin
                    bus.regReadEnable = 1'b1;
                    bus.ADR_1         = r_op1;
                    bus.ADR_2         = (r_opcode == OP_MOV) ? '0 : r_op2;
                end
                WRITEBACK: begin
                    bus.regWriteEnable = 1'b1;
                    case (r_opcode)
                        OP_STR: begin
                            bus.ADR_3      = r_op1;
                            bus.write_data = r_op2;
                        end
                        OP_ADD: begin
                            bus.ADR_3   = r_op1;
                            bus.ALU_sel = ALU_ADD;
                        end
                        OP_SUB: begin
                            bus.ADR_3   = r_op1;
                            bus.ALU_sel = ALU_SUB;
                        end
                        OP_MOV: begin
                            bus.ADR_3   = r_op2;
                            bus.ALU_sel = ALU_PASS;
                        end
                        default: ;
                    endcase
                end
                EXECUTE: begin
                    case (r_opcode)
                        OP_JMP: begin
                            bus.PC_load = r_op2;
                            bus.PC_en   = 1'b1;
                        end
`ifdef CU_CALL_STACK_EN
                        OP_CALL: begin
                            if (!w_full) begin
                                bus.PC_load = r_op2;
                                bus.PC_en   = 1'b1;
                            end
                        end
                        OP_RET: begin
                            if (!w_empty) begin
                                bus.PC_load = r_stack[w_top_idx];
                                bus.PC_en   = 1'b1;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit_v3.sv
// Bench for control_unit_v3: directed scenarios plus a randomized instruction
// stream checked against a per-instruction behavioural model.
module tb_control_unit_v3;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
`ifdef CU_CALL_STACK_EN
    localparam bit STACK_EN = 1'b1;
`else
    localparam bit STACK_EN = 1'b0;
`endif

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_STR  = 8'h01;
    localparam logic [7:0] OP_ADD  = 8'h03;
    localparam logic [7:0] OP_SUB  = 8'h04;
    localparam logic [7:0] OP_JMP  = 8'h19;
    localparam logic [7:0] OP_CALL = 8'h1A;
    localparam logic [7:0] OP_RET  = 8'h1B;
    localparam logic [7:0] OP_MOV  = 8'h1C;

    logic clk = 1'b0;
    logic rst = 1'b1;

    control_unit_v3_if #(.DATA_W(DW)) bus ();

    control_unit_v3 #(.DATA_W(DW), .STACK_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // observations of one instruction
    int         obs_cycles, obs_nread, obs_nwrite, obs_nillegal, obs_xen, obs_xinc;
    logic [7:0] obs_adr1, obs_adr2, obs_adr3, obs_alu, obs_wdata, obs_xload;

    // model expectations
    int         exp_cycles, exp_nread, exp_nwrite, exp_nillegal, exp_xen, exp_xinc;
    logic [7:0] exp_adr1, exp_adr2, exp_adr3, exp_alu, exp_wdata, exp_xload;
    logic       exp_ovf = 1'b0;
    logic       exp_unf = 1'b0;
    logic [7:0] stk[$];

    function automatic logic [56:0] all_outs();
        return {bus.PC_load, bus.PC_inc, bus.PC_en, bus.MAR_load, bus.IR_load,
                bus.write_data, bus.ALU_sel, bus.ADR_1, bus.ADR_2, bus.ADR_3,
                bus.regReadEnable, bus.regWriteEnable, bus.stack_overflow,
                bus.stack_underflow, bus.illegal_op};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Runs one instruction starting from a FETCH cycle, until the next FETCH.
    // The read/write flags go high after rd_wait/wr_wait cycles of the request.
    task automatic exec_instr(input logic [7:0] opc, input logic [7:0] op1, input logic [7:0] op2,
                              input int rd_wait, input int wr_wait, input logic [7:0] pcv);
        int c;
        int rk;
        int wk;
        bit done;
        c = 0; rk = 0; wk = 0; done = 1'b0;
        obs_nread = 0; obs_nwrite = 0; obs_nillegal = 0; obs_xen = 0; obs_xinc = 0;
        obs_adr1 = '0; obs_adr2 = '0; obs_adr3 = '0; obs_alu = '0; obs_wdata = '0; obs_xload = '0;
        bus.pc_value = pcv;
        while (!done && c < 64) begin
            if (c > 0 && bus.MAR_load === 1'b1) begin
                done = 1'b1;
            end else begin
                if (bus.regReadEnable === 1'b1) begin
                    if (obs_nread == 0) begin
                        obs_adr1 = bus.ADR_1;
                        obs_adr2 = bus.ADR_2;
                    end
                    obs_nread++;
                end
                if (bus.regWriteEnable === 1'b1) begin
                    if (obs_nwrite == 0) begin
                        obs_adr3  = bus.ADR_3;
                        obs_alu   = bus.ALU_sel;
                        obs_wdata = bus.write_data;
                    end
                    obs_nwrite++;
                end
                if (bus.illegal_op === 1'b1) obs_nillegal++;
                if (bus.PC_en === 1'b1 && bus.IR_load !== 1'b1) begin
                    obs_xen++;
                    obs_xload = bus.PC_load;
                end
                if (bus.PC_inc === 1'b1 && bus.IR_load !== 1'b1) obs_xinc++;
                bus.command_word    = (bus.IR_load === 1'b1) ? {opc, op1, op2} : 24'($urandom);
                bus.ReadyRegFlag[0] = (bus.regReadEnable === 1'b1) ? (rk >= rd_wait) : 1'($urandom);
                bus.ReadyRegFlag[1] = (bus.regWriteEnable === 1'b1) ? (wk >= wr_wait) : 1'($urandom);
                if (bus.regReadEnable === 1'b1) rk++;
                if (bus.regWriteEnable === 1'b1) wk++;
                step();
                c++;
            end
        end
        obs_cycles = c;
    endtask

    // Behavioural model of one instruction: cycle count, handshake counts,
    // driven fields, and the return-stack effect.
    task automatic model_instr(input logic [7:0] opc, input logic [7:0] op1, input logic [7:0] op2,
                               input int rd_wait, input int wr_wait, input logic [7:0] pcv);
        exp_cycles = 3; exp_nread = 0; exp_nwrite = 0; exp_nillegal = 0; exp_xen = 0; exp_xinc = 0;
        exp_adr1 = '0; exp_adr2 = '0; exp_adr3 = '0; exp_alu = '0; exp_wdata = '0; exp_xload = '0;
        if (opc == OP_NOP) begin
            exp_cycles = 3;
        end else if (opc == OP_STR) begin
            exp_nwrite = wr_wait + 1;
            exp_cycles = 3 + exp_nwrite;
            exp_adr3   = op1;
            exp_wdata  = op2;
        end else if (opc == OP_ADD || opc == OP_SUB || opc == OP_MOV) begin
            exp_nread  = rd_wait + 1;
            exp_nwrite = wr_wait + 1;
            exp_cycles = 3 + exp_nread + exp_nwrite;
            exp_adr1   = op1;
            exp_adr2   = (opc == OP_MOV) ? 8'h00 : op2;
            exp_adr3   = (opc == OP_MOV) ? op2 : op1;
            exp_alu    = (opc == OP_ADD) ? 8'h01 : (opc == OP_SUB) ? 8'h02 : 8'h00;
        end else if (opc == OP_JMP) begin
            exp_cycles = 4;
            exp_xen    = 1;
            exp_xload  = op2;
        end else if (STACK_EN && opc == OP_CALL) begin
            exp_cycles = 4;
            if (stk.size() < DEPTH) begin
                stk.push_back(pcv);
                exp_xen   = 1;
                exp_xload = op2;
            end else begin
                exp_ovf = 1'b1;
            end
        end else if (STACK_EN && opc == OP_RET) begin
            exp_cycles = 4;
            if (stk.size() > 0) begin
                exp_xload = stk.pop_back();
                exp_xen   = 1;
            end else begin
                exp_unf = 1'b1;
            end
        end else begin
            exp_nillegal = 1;
        end
    endtask

    task automatic test_reset();
        bus.command_word = '0;
        bus.pc_value     = '0;
        bus.ReadyRegFlag = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (dut.current_state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want 0", dut.current_state);
        end
        n_checks++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", all_outs());
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.MAR_load, bus.IR_load, bus.PC_en} !== 3'b100) begin
            n_fail++;
            $display("FAIL first_fetch: MAR/IR/PC_en got %b want 100", {bus.MAR_load, bus.IR_load, bus.PC_en});
        end
    endtask

    task automatic test_str_imm();
        exec_instr(8'h01, 8'h02, 8'h03, 0, 0, 8'h00);
        n_checks++;
        if (obs_cycles !== 4) begin
            n_fail++;
            $display("FAIL str_cycles: got %0d want 4", obs_cycles);
        end
        n_checks++;
        if ({obs_nwrite, obs_nread, obs_nillegal} !== {32'd1, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL str_handshake: writes %0d reads %0d illegal %0d want 1 0 0", obs_nwrite, obs_nread, obs_nillegal);
        end
        n_checks++;
        if ({obs_adr3, obs_wdata, obs_alu} !== {8'd2, 8'd3, 8'd0}) begin
            n_fail++;
            $display("FAIL str_fields: ADR_3 %0d data %0d alu %0d want 2 3 0", obs_adr3, obs_wdata, obs_alu);
        end
    endtask

    task automatic test_add_hold();
        exec_instr(8'h03, 8'h08, 8'h09, 3, 0, 8'h00);
        n_checks++;
        if (obs_nread !== 4) begin
            n_fail++;
            $display("FAIL add_read_len: got %0d want 4", obs_nread);
        end
        n_checks++;
        if ({obs_adr1, obs_adr2} !== {8'd8, 8'd9}) begin
            n_fail++;
            $display("FAIL add_read_adr: ADR_1 %0d ADR_2 %0d want 8 9", obs_adr1, obs_adr2);
        end
        n_checks++;
        if ({obs_adr3, obs_alu, obs_wdata} !== {8'd8, 8'd1, 8'd0}) begin
            n_fail++;
            $display("FAIL add_wb: ADR_3 %0d alu %0d data %0d want 8 1 0", obs_adr3, obs_alu, obs_wdata);
        end
        n_checks++;
        if ({obs_cycles, obs_nwrite} !== {32'd8, 32'd1}) begin
            n_fail++;
            $display("FAIL add_cycles: cycles %0d writes %0d want 8 1", obs_cycles, obs_nwrite);
        end
    endtask

    task automatic test_jmp();
        exec_instr(8'h19, 8'h00, 8'h0A, 0, 0, 8'h33);
        n_checks++;
        if ({obs_xen, obs_xinc} !== {32'd1, 32'd0}) begin
            n_fail++;
            $display("FAIL jmp_strobes: PC_en %0d PC_inc %0d want 1 0", obs_xen, obs_xinc);
        end
        n_checks++;
        if (obs_xload !== 8'h0A) begin
            n_fail++;
            $display("FAIL jmp_target: got %h want 0a", obs_xload);
        end
        n_checks++;
        if (obs_cycles !== 4) begin
            n_fail++;
            $display("FAIL jmp_cycles: got %0d want 4", obs_cycles);
        end
    endtask

    task automatic test_illegal();
        exec_instr(8'h7F, 8'h11, 8'h22, 0, 0, 8'h00);
        n_checks++;
        if ({obs_nillegal, obs_cycles} !== {32'd1, 32'd3}) begin
            n_fail++;
            $display("FAIL illegal_pulse: pulses %0d cycles %0d want 1 3", obs_nillegal, obs_cycles);
        end
        n_checks++;
        if ({obs_nread, obs_nwrite, obs_xen} !== {32'd0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL illegal_side: reads %0d writes %0d pc_en %0d want 0 0 0", obs_nread, obs_nwrite, obs_xen);
        end
        exec_instr(8'h00, 8'h11, 8'h22, 0, 0, 8'h00);
        n_checks++;
        if ({obs_nillegal, obs_cycles} !== {32'd0, 32'd3}) begin
            n_fail++;
            $display("FAIL nop: pulses %0d cycles %0d want 0 3", obs_nillegal, obs_cycles);
        end
    endtask

    task automatic test_stack();
`ifdef CU_CALL_STACK_EN
        exec_instr(OP_RET, 8'h00, 8'h00, 0, 0, 8'h00);
        n_checks++;
        if ({obs_xen, obs_cycles} !== {32'd0, 32'd4} || bus.stack_underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ret_empty: pc_en %0d cycles %0d underflow %b want 0 4 1", obs_xen, obs_cycles, bus.stack_underflow);
        end
        exec_instr(OP_CALL, 8'h00, 8'h0B, 0, 0, 8'h05);
        n_checks++;
        if ({obs_xen, 24'd0, obs_xload} !== {32'd1, 24'd0, 8'h0B}) begin
            n_fail++;
            $display("FAIL call_jump: pc_en %0d target %h want 1 0b", obs_xen, obs_xload);
        end
        exec_instr(OP_RET, 8'h00, 8'h00, 0, 0, 8'hEE);
        n_checks++;
        if ({obs_xen, 24'd0, obs_xload} !== {32'd1, 24'd0, 8'h05}) begin
            n_fail++;
            $display("FAIL ret_return: pc_en %0d target %h want 1 05", obs_xen, obs_xload);
        end
        for (int i = 0; i < 5; i++) begin
            exec_instr(OP_CALL, 8'h00, 8'(8'h40 + i), 0, 0, 8'(8'h20 + i));
            n_checks++;
            if (i < 4 && (obs_xen !== 1 || obs_xload !== 8'(8'h40 + i) || bus.stack_overflow !== 1'b0)) begin
                n_fail++;
                $display("FAIL call_push%0d: pc_en %0d target %h overflow %b want 1 %h 0", i, obs_xen, obs_xload, bus.stack_overflow, 8'(8'h40 + i));
            end else if (i == 4 && (obs_xen !== 0 || bus.stack_overflow !== 1'b1)) begin
                n_fail++;
                $display("FAIL call_overflow: pc_en %0d overflow %b want 0 1", obs_xen, bus.stack_overflow);
            end
        end
        for (int i = 0; i < 4; i++) begin
            exec_instr(OP_RET, 8'h00, 8'h00, 0, 0, 8'h00);
            n_checks++;
            if (obs_xen !== 1 || obs_xload !== 8'(8'h23 - i)) begin
                n_fail++;
                $display("FAIL ret_pop%0d: pc_en %0d target %h want 1 %h", i, obs_xen, obs_xload, 8'(8'h23 - i));
            end
        end
`else
        exec_instr(OP_CALL, 8'h00, 8'h0B, 0, 0, 8'h05);
        n_checks++;
        if ({obs_nillegal, obs_cycles, obs_xen} !== {32'd1, 32'd3, 32'd0}) begin
            n_fail++;
            $display("FAIL call_disabled: pulses %0d cycles %0d pc_en %0d want 1 3 0", obs_nillegal, obs_cycles, obs_xen);
        end
        exec_instr(OP_RET, 8'h00, 8'h00, 0, 0, 8'h00);
        n_checks++;
        if ({obs_nillegal, obs_cycles, obs_xen} !== {32'd1, 32'd3, 32'd0}) begin
            n_fail++;
            $display("FAIL ret_disabled: pulses %0d cycles %0d pc_en %0d want 1 3 0", obs_nillegal, obs_cycles, obs_xen);
        end
        n_checks++;
        if ({bus.stack_overflow, bus.stack_underflow} !== 2'b00) begin
            n_fail++;
            $display("FAIL stack_flags_disabled: got %b want 00", {bus.stack_overflow, bus.stack_underflow});
        end
`endif
    endtask

    task automatic test_reset_mid_wb();
        bus.command_word = {8'h01, 8'h05, 8'h06};
        bus.ReadyRegFlag = 2'b01;
        repeat (3) step();
        n_checks++;
        if (bus.regWriteEnable !== 1'b1) begin
            n_fail++;
            $display("FAIL midwb_reach: regWriteEnable %b want 1", bus.regWriteEnable);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (dut.current_state !== 3'd0) begin
            n_fail++;
            $display("FAIL midwb_state: got %0d want 0", dut.current_state);
        end
        n_checks++;
        if ({bus.regWriteEnable, bus.stack_overflow, bus.stack_underflow} !== 3'b000 || all_outs() !== '0) begin
            n_fail++;
            $display("FAIL midwb_outputs: wr %b ovf %b unf %b outs %h want all 0", bus.regWriteEnable, bus.stack_overflow, bus.stack_underflow, all_outs());
        end
        @(negedge clk);
        rst = 1'b0;
        stk.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        #1;
        n_checks++;
        if (bus.MAR_load !== 1'b1) begin
            n_fail++;
            $display("FAIL midwb_refetch: MAR_load %b want 1", bus.MAR_load);
        end
    endtask

    task automatic test_random();
        logic [7:0] opc, op1, op2, pcv;
        int         sel, rw, ww;
        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 8));
            op1 = 8'($urandom);
            op2 = 8'($urandom);
            pcv = 8'($urandom);
            rw  = int'($urandom_range(0, 3));
            ww  = int'($urandom_range(0, 3));
            case (sel)
                0: opc = OP_NOP;
                1: opc = OP_STR;
                2: opc = OP_ADD;
                3: opc = OP_SUB;
                4: opc = OP_MOV;
                5: opc = OP_JMP;
                6: opc = OP_CALL;
                7: opc = OP_RET;
                default: begin
                    do opc = 8'($urandom);
                    while (opc inside {OP_NOP, OP_STR, OP_ADD, OP_SUB, OP_JMP, OP_CALL, OP_RET, OP_MOV});
                end
            endcase
            model_instr(opc, op1, op2, rw, ww, pcv);
            exec_instr(opc, op1, op2, rw, ww, pcv);
            n_checks++;
            if (obs_cycles !== exp_cycles) begin
                n_fail++;
                $display("FAIL rnd%0d_cycles op %h: got %0d want %0d", n, opc, obs_cycles, exp_cycles);
            end
            n_checks++;
            if ({obs_nread, obs_nwrite, obs_nillegal, obs_xen, obs_xinc} !==
                {exp_nread, exp_nwrite, exp_nillegal, exp_xen, exp_xinc}) begin
                n_fail++;
                $display("FAIL rnd%0d_counts op %h: rd %0d wr %0d ill %0d en %0d inc %0d want %0d %0d %0d %0d %0d",
                         n, opc, obs_nread, obs_nwrite, obs_nillegal, obs_xen, obs_xinc,
                         exp_nread, exp_nwrite, exp_nillegal, exp_xen, exp_xinc);
            end
            n_checks++;
            if ({obs_adr1, obs_adr2, obs_adr3, obs_alu, obs_wdata, obs_xload} !==
                {exp_adr1, exp_adr2, exp_adr3, exp_alu, exp_wdata, exp_xload}) begin
                n_fail++;
                $display("FAIL rnd%0d_fields op %h: a1 %h a2 %h a3 %h alu %h wd %h pc %h want %h %h %h %h %h %h",
                         n, opc, obs_adr1, obs_adr2, obs_adr3, obs_alu, obs_wdata, obs_xload,
                         exp_adr1, exp_adr2, exp_adr3, exp_alu, exp_wdata, exp_xload);
            end
            n_checks++;
            if ({bus.stack_overflow, bus.stack_underflow} !== {exp_ovf, exp_unf}) begin
                n_fail++;
                $display("FAIL rnd%0d_flags op %h: ovf/unf %b want %b", n, opc,
                         {bus.stack_overflow, bus.stack_underflow}, {exp_ovf, exp_unf});
            end
        end
    endtask

    initial begin
        test_reset();
        test_str_imm();
        test_add_hold();
        test_jmp();
        test_illegal();
        test_stack();
        test_reset_mid_wb();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bench did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/control_unit_v3.md
CONTROL_UNIT_V3 -- requirements
Module: control_unit_v3

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of opcode, operand fields, addresses and data.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, power of two >= 2: return-stack entries.
REQ-003 SHALL use a single clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- command_word  in  3*DATA_W  {opcode, op1, op2}, MSB field = opcode
- pc_value  in  DATA_W  current PC, already incremented
- ReadyRegFlag  in  2  bit0 = read data valid; bit1 = write accepted
- PC_load  out  DATA_W  PC load value
- PC_inc  out  1  PC increment request
- PC_en  out  1  PC update strobe
- MAR_load  out  1  MAR load strobe
- IR_load  out  1  IR load strobe
- write_data  out  DATA_W  immediate write data
- ALU_sel  out  DATA_W  ALU operation: 0x00 PASS, 0x01 ADD, 0x02 SUB
- ADR_1, ADR_2, ADR_3  out  DATA_W each  ADR_1/ADR_2 = register read addresses; ADR_3 = register write address
- regReadEnable, regWriteEnable  out  1 each  register-file handshake requests
- stack_overflow, stack_underflow  out  1 each  sticky error flags
- illegal_op  out  1  one-cycle pulse on undefined opcode

Function
REQ-005 SHALL hold the state in a 3-bit register named current_state: FETCH=0, LOAD_IR=1, DECODE=2, READ=3, EXECUTE=4, WRITEBACK=5; encodings 6-7 go to FETCH on the next edge.
REQ-006 SHALL derive outputs from current_state and the latched instruction only; any output not stated for a state is 0.
REQ-007 FETCH: MAR_load=1; next state LOAD_IR.
REQ-008 LOAD_IR: IR_load=1, PC_inc=1, PC_en=1; latch command_word internally; next state DECODE.
REQ-009 DECODE SHALL dispatch on the latched opcode:
- 0x00 NOP -> FETCH
- 0x01 STR_IMM -> WRITEBACK
- 0x03 ADD, 0x04 SUB, 0x1C MOV -> READ
- 0x19 JMP, 0x1A CALL, 0x1B RET -> EXECUTE
- any other opcode: illegal_op=1 for this cycle -> FETCH
REQ-010 READ: regReadEnable=1, ADR_1=op1; ADR_2=op2 for ADD/SUB, 0 for MOV.
- Holds until ReadyRegFlag[0]=1 is sampled at a rising edge, then WRITEBACK.
- Minimum one cycle in READ even when the flag is already high.
REQ-011 WRITEBACK: regWriteEnable=1.
- STR_IMM: ADR_3=op1, write_data=op2.
- ADD: ADR_3=op1, ALU_sel=0x01. SUB: ADR_3=op1, ALU_sel=0x02. MOV: ADR_3=op2, ALU_sel=0x00.
- Holds until ReadyRegFlag[1]=1 is sampled, then FETCH; minimum one cycle.
REQ-012 EXECUTE is one cycle, then FETCH.
- JMP: PC_load=op2, PC_en=1, PC_inc=0.
- CALL, stack not full: push pc_value, then PC_load=op2, PC_en=1.
- RET, stack not empty: pop; PC_load=popped value, PC_en=1.
REQ-013 CALL with STACK_DEPTH entries in use SHALL not push and SHALL not jump; stack_overflow set to 1.
REQ-014 RET with stack empty SHALL not pop and SHALL not jump; stack_underflow set to 1.
REQ-015 Stack pointer is DATA_W-independent, log2(STACK_DEPTH)+1 bits; no wrap-around (a full stack rejects further pushes).
REQ-016 Latency with handshake flags already high, from FETCH entry to the next FETCH entry:
- NOP or illegal: 3 cycles
- STR_IMM, JMP, CALL, RET: 4 cycles
- ADD, SUB, MOV: 5 cycles
REQ-017 Changes on command_word outside LOAD_IR SHALL not affect the executing instruction.

Reset
REQ-018 rst=1 SHALL immediately force current_state=FETCH, whatever the state, including mid-handshake.
REQ-019 rst=1 SHALL immediately clear all of these to 0: latched instruction, stack pointer, stack contents, stack_overflow, stack_underflow, and every output.
REQ-020 First FETCH after reset SHALL occur at the first rising edge with rst=0.

Configuration
REQ-021 Macro CU_CALL_STACK_EN defined: CALL/RET behave per REQ-012 to REQ-015.
REQ-022 CU_CALL_STACK_EN undefined:
- No stack storage is built.
- 0x1A and 0x1B are treated as illegal opcodes per REQ-009.
- stack_overflow and stack_underflow are tied to 0.

Verification
REQ-023 Reset, then STR_IMM {0x01,0x02,0x03}, ReadyRegFlag=2'b11 -> WRITEBACK with ADR_3=2, write_data=3, regWriteEnable=1 for 1 cycle; 4 cycles total.
REQ-024 ADD {0x03,0x08,0x09}, ReadyRegFlag[0] held 0 for 3 cycles -> READ lasts 4 cycles with ADR_1=8, ADR_2=9; then WRITEBACK with ADR_3=8, ALU_sel=1.
REQ-025 JMP {0x19,0x00,0x0A} -> EXECUTE: PC_load=10, PC_en=1, PC_inc=0.
REQ-026 CALL 0x0B with pc_value=0x05, then RET -> RET EXECUTE drives PC_load=5; five CALLs with STACK_DEPTH=4 -> fifth does not jump and stack_overflow=1.
REQ-027 RET on empty stack -> no PC_en in EXECUTE, stack_underflow=1; opcode 0x7F -> illegal_op pulses for 1 cycle, then FETCH.
REQ-028 rst asserted mid-WRITEBACK -> current_state=0, regWriteEnable=0 and flags cleared before the next clock edge.
